fetch_stall_ctrl: RTL and testbench

FETCH_STALL_CTRL -- requirements
Module: fetch_stall_ctrl

---
 rtl/fetch_stall_ctrl_pkg.sv | 24 ++
 rtl/stall_timer.sv | 29 ++
 rtl/fetch_stall_ctrl.sv | 119 +++++++++++
 tb/tb_fetch_stall_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_stall_ctrl_pkg.sv
// Shared constants and types for the fetch/stall controller.
// The optional stall-cycle counter is enabled by defining STALL_PERF_EN.
package fetch_stall_ctrl_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0000;
  localparam logic [15:0] PC_INC    = 16'd2;

  localparam logic [1:0] STALL_NONE = 2'b00;
  localparam logic [1:0] STALL_ONE  = 2'b01;
  localparam logic [1:0] STALL_TWO  = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  // The cycle that sees a non-zero stall code is itself the first bubble,
  // so the timer only has to cover the bubbles that follow it.
  function automatic logic [1:0] bubbles_after_first(input logic [1:0] code);
    return (code == STALL_ONE) ? 2'd0 : 2'd1;
  endfunction

endpackage

// File: rtl/stall_timer.sv
// 2-bit loadable down-counter that tracks the remaining stall bubbles.
module stall_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [1:0] load_val,
  input  logic       dec,
  output logic [1:0] value,
  output logic       busy
);

  logic [1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 2'd0)) begin
      count <= count - 2'd1;
    end
  end

  assign value = count;
  assign busy  = (count != 2'd0);

endmodule

// File: rtl/fetch_stall_ctrl.sv
// Fetch-stage PC / IF-ID register control with hazard stalls, branch flush and HALT.
// Define STALL_PERF_EN to add the saturating stall_cnt performance counter.
module fetch_stall_ctrl
  import fetch_stall_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  stall_c,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        halt_id,
  input  logic [15:0] imem_instr,
  output logic [15:0] pc_out,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc2,
  output logic        if_id_valid,
  output logic        bubble_id_ex,
  output logic        stall_busy
`ifdef STALL_PERF_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  state_t      state, state_nxt;
  logic [15:0] pc_nxt, instr_nxt, pc2_nxt;
  logic        valid_nxt;
  logic        timer_load, timer_dec;
  logic [1:0]  timer_load_val, timer_val;
  logic        timer_busy;

  stall_timer u_stall_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_load_val),
    .dec      (timer_dec),
    .value    (timer_val),
    .busy     (timer_busy)
  );

  assign stall_busy = timer_busy;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc_out;
    instr_nxt      = if_id_instr;
    pc2_nxt        = if_id_pc2;
    valid_nxt      = if_id_valid;
    timer_load     = 1'b0;
    timer_load_val = 2'd0;
    timer_dec      = 1'b0;
    bubble_id_ex   = 1'b0;

    unique case (state)
      ST_RUN: begin
        if (stall_c != STALL_NONE) begin
          // Stall beats both halt and branch; the hazard unit re-evaluates afterwards.
          bubble_id_ex   = 1'b1;
          timer_load     = 1'b1;
          timer_load_val = bubbles_after_first(stall_c);
          if (bubbles_after_first(stall_c) != 2'd0) state_nxt = ST_STALL;
        end else if (halt_id) begin
          // HALT takes priority over a simultaneous taken branch.
          state_nxt = ST_HALT;
          instr_nxt = NOP_INSTR;
          valid_nxt = 1'b0;
        end else if (branch_taken) begin
          pc_nxt    = branch_target;
          instr_nxt = NOP_INSTR;
          valid_nxt = 1'b0;
        end else begin
          pc_nxt    = pc_out + PC_INC;
          instr_nxt = imem_instr;
          pc2_nxt   = pc_out + PC_INC;
          valid_nxt = 1'b1;
        end
      end
      ST_STALL: begin
        bubble_id_ex = 1'b1;
        timer_dec    = 1'b1;
        if (timer_val <= 2'd1) state_nxt = ST_RUN;
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      pc_out      <= 16'h0000;
      if_id_instr <= NOP_INSTR;
      if_id_pc2   <= 16'h0000;
      if_id_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc_out      <= pc_nxt;
      if_id_instr <= instr_nxt;
      if_id_pc2   <= pc2_nxt;
      if_id_valid <= valid_nxt;
    end
  end

`ifdef STALL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'h0000;
    end else if (bubble_id_ex && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Self-checking bench for fetch_stall_ctrl: directed scenarios then random
// stimulus, compared against a bubble-count reference model.
module tb_fetch_stall_ctrl;

  localparam logic [15:0] NOP = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  stall_c;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        halt_id;
  logic [15:0] imem_instr;
  logic [15:0] pc_out;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc2;
  logic        if_id_valid;
  logic        bubble_id_ex;
  logic        stall_busy;
`ifdef STALL_PERF_EN
  logic [15:0] stall_cnt;
`endif

  fetch_stall_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_c       (stall_c),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt_id       (halt_id),
    .imem_instr    (imem_instr),
    .pc_out        (pc_out),
    .if_id_instr   (if_id_instr),
    .if_id_pc2     (if_id_pc2),
    .if_id_valid   (if_id_valid),
    .bubble_id_ex  (bubble_id_ex),
    .stall_busy    (stall_busy)
`ifdef STALL_PERF_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] imem_of(input logic [15:0] addr);
    if (addr == 16'h0000) return 16'h1111;
    if (addr == 16'h0002) return 16'h2222;
    return addr ^ 16'hA5C3;
  endfunction

  assign imem_instr = imem_of(pc_out);

  int total = 0;
  int bad   = 0;

  // Reference model: architectural PC / IF-ID plus bubbles still owed.
  logic [15:0] m_pc, m_instr, m_pc2;
  logic        m_valid;
  int          m_owed;
  bit          m_halted;
  int          m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = NOP; m_pc2 = 16'h0000; m_valid = 1'b0;
    m_owed = 0; m_halted = 0; m_cnt = 0;
  endtask

  function automatic bit model_bubble();
    return (m_owed > 0) || (!m_halted && stall_c != 2'b00);
  endfunction

  task automatic check_outputs();
    check("pc_out", {16'h0, pc_out}, {16'h0, m_pc});
    check("if_id_instr", {16'h0, if_id_instr}, {16'h0, m_instr});
    check("if_id_pc2", {16'h0, if_id_pc2}, {16'h0, m_pc2});
    check("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
    check("stall_busy", {31'h0, stall_busy}, {31'h0, (m_owed > 0)});
    check("bubble_id_ex", {31'h0, bubble_id_ex}, {31'h0, model_bubble()});
`ifdef STALL_PERF_EN
    check("stall_cnt", {16'h0, stall_cnt}, m_cnt);
`endif
  endtask

  task automatic model_step();
    if (model_bubble() && m_cnt < 65535) m_cnt++;
    if (m_halted) begin
      // frozen until reset
    end else if (m_owed > 0) begin
      m_owed--;
    end else if (stall_c != 2'b00) begin
      // total bubbles: 1 for code 01, 2 otherwise; this cycle is the first
      m_owed = (stall_c == 2'b01) ? 0 : 1;
    end else if (halt_id) begin
      m_halted = 1; m_instr = NOP; m_valid = 1'b0;
    end else if (branch_taken) begin
      m_pc = branch_target; m_instr = NOP; m_valid = 1'b0;
    end else begin
      m_instr = imem_of(m_pc);
      m_pc2   = m_pc + 16'd2;
      m_pc    = m_pc + 16'd2;
      m_valid = 1'b1;
    end
  endtask

  // Called just after a negedge; returns just after the following negedge.
  task automatic cycle(input logic [1:0] s, input logic b, input logic [15:0] t, input logic h);
    stall_c = s; branch_taken = b; branch_target = t; halt_id = h;
    #1;
    check_outputs();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    stall_c = 2'b00; branch_taken = 1'b0; branch_target = 16'h0; halt_id = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    stall_c = 2'b00; branch_taken = 1'b0; branch_target = 16'h0; halt_id = 1'b0;
    @(negedge clk);
    apply_reset();

    // Straight-line fetch: 0x1111 then 0x2222
    repeat (3) cycle(2'b00, 1'b0, 16'h0, 1'b0);
    // One-bubble stall at pc 6, then two-bubble stall with stall_c dropping
    cycle(2'b01, 1'b0, 16'h0, 1'b0);
    repeat (2) cycle(2'b00, 1'b0, 16'h0, 1'b0);
    cycle(2'b10, 1'b0, 16'h0, 1'b0);
    repeat (3) cycle(2'b00, 1'b0, 16'h0, 1'b0);
    cycle(2'b11, 1'b0, 16'h0, 1'b0);
    repeat (2) cycle(2'b00, 1'b0, 16'h0, 1'b0);
    // Branch taken, then branch colliding with a stall
    cycle(2'b00, 1'b1, 16'h0040, 1'b0);
    check("branch_pc", {16'h0, pc_out}, 32'h0040);
    cycle(2'b01, 1'b1, 16'h0080, 1'b0);
    repeat (2) cycle(2'b00, 1'b0, 16'h0, 1'b0);
    // Odd target used verbatim, then PC wrap at 0xFFFE
    cycle(2'b00, 1'b1, 16'h1235, 1'b0);
    cycle(2'b00, 1'b1, 16'hFFFE, 1'b0);
    cycle(2'b00, 1'b0, 16'h0, 1'b0);
    check("wrap_pc", {16'h0, pc_out}, 32'h0000);
    // Halt holds through stall codes and branches
    cycle(2'b00, 1'b0, 16'h0, 1'b1);
    cycle(2'b10, 1'b0, 16'h0, 1'b0);
    cycle(2'b00, 1'b1, 16'h0100, 1'b0);
    cycle(2'b00, 1'b0, 16'h0, 1'b0);
    apply_reset();

    // Reset during the second bubble of a two-bubble stall
    repeat (2) cycle(2'b00, 1'b0, 16'h0, 1'b0);
    cycle(2'b10, 1'b0, 16'h0, 1'b0);
    stall_c = 2'b00;
    #1;
    check("second_bubble", {31'h0, bubble_id_ex}, 32'h1);
    apply_reset();
    repeat (3) cycle(2'b00, 1'b0, 16'h0, 1'b0);

    // Randomized stimulus with periodic resets
    for (int i = 0; i < 800; i++) begin
      logic [1:0]  s;
      logic        b, h;
      logic [15:0] t;
      s = ($urandom_range(0, 7) < 6) ? 2'b00 : 2'($urandom_range(1, 3));
      b = ($urandom_range(0, 4) == 0);
      t = 16'($urandom);
      h = ($urandom_range(0, 59) == 0);
      if (i % 150 == 149) apply_reset();
      else cycle(s, b, t, h);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
